// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store access stage: size codes (same
// encoding the downstream extension stage decodes), FSM states, timer width.
package mem_access_unit_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Wide enough for the largest supported timeout (65535).
  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_e;

  // Unsigned variants only make sense for loads; 011/11x are never legal.
  function automatic logic size_legal(input logic [2:0] size, input logic write);
    case (size)
      SZ_B, SZ_H, SZ_W: return 1'b1;
      SZ_BU, SZ_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the datapath request/response handshake and the RAM bus.
// master: the access unit itself; slave: its environment (datapath + RAM).
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [2:0]            resp_extend;
  logic                  resp_err;

  logic                  mem_req;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_extend, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_extend, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one access: legality/alignment check, byte enables,
// store data moved up into its lanes and load data moved down to bit 0.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic        write,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_lane
);

  logic       aligned;
  logic [4:0] shamt;

  assign shamt = {offset, 3'b000};

  // Natural alignment and lane mask per access width.
  always_comb begin
    aligned = 1'b0;
    be      = 4'b0000;
    case (size)
      SZ_B, SZ_BU: begin
        aligned = 1'b1;
        be      = 4'b0001 << offset;
      end
      SZ_H, SZ_HU: begin
        aligned = ~offset[0];
        be      = 4'b0011 << offset;
      end
      SZ_W: begin
        aligned = (offset == 2'b00);
        be      = 4'b1111;
      end
      default: begin
        aligned = 1'b0;
        be      = 4'b0000;
      end
    endcase
  end

  assign legal      = aligned & size_legal(size, write);
  // Bytes outside be are left as the shifted value; the RAM ignores them.
  assign wdata_lane = wdata << shamt;
  // No extension here: upper bits are whatever the RAM word held above the lane.
  assign rdata_lane = rdata >> shamt;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access stage: accepts one request at a time, checks it, runs the
// req/ack handshake with the data RAM (with an abort timer) and returns
// lane-aligned, unextended load data plus the size code for the extension stage.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.master bus
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  mau_state_e            state;
  logic [2:0]            cap_size;
  logic                  cap_write;
  logic [1:0]            cap_off;
  logic [TMR_W-1:0]      tmr;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic [2:0]            resp_extend_q;
  logic                  resp_err_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [3:0]            mem_be_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;

  logic                  in_idle;
  logic [2:0]            lane_size;
  logic                  lane_write;
  logic [1:0]            lane_off;
  logic                  lane_legal;
  logic [3:0]            lane_be;
  logic [31:0]           lane_wdata;
  logic [31:0]           lane_rdata;

  // In IDLE the lane logic looks at the live request (to decide and capture);
  // afterwards it works on the captured copy so the load shift uses the
  // original offset when the ack arrives.
  assign in_idle    = (state == ST_IDLE);
  assign lane_size  = in_idle ? bus.req_size      : cap_size;
  assign lane_write = in_idle ? bus.req_write     : cap_write;
  assign lane_off   = in_idle ? bus.req_addr[1:0] : cap_off;

  mem_lane_align u_lane (
    .size       (lane_size),
    .write      (lane_write),
    .offset     (lane_off),
    .wdata      (bus.req_wdata),
    .rdata      (bus.mem_rdata),
    .legal      (lane_legal),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_lane (lane_rdata)
  );

  // Sequencer: IDLE -> (ACCESS ->) RESP -> IDLE, all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cap_size      <= '0;
      cap_write     <= 1'b0;
      cap_off       <= '0;
      tmr           <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_extend_q <= '0;
      resp_err_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cap_size    <= bus.req_size;
            cap_write   <= bus.req_write;
            cap_off     <= bus.req_addr[1:0];
            tmr         <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b0;
            if (lane_legal) begin
              state       <= ST_ACCESS;
              err_q       <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_write;
              mem_be_q    <= lane_be;
              mem_addr_q  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_q <= lane_wdata;
            end else begin
              // Rejected requests never touch the RAM.
              state <= ST_RESP;
              err_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the limit cycle still completes normally.
          if (bus.mem_ack) begin
            state     <= ST_RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            rdata_q   <= cap_write ? 32'h0 : lane_rdata;
          end else if (tmr == TMR_LAST) begin
            state     <= ST_RESP;
            tmr       <= tmr + 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            err_q     <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          req_ready_q   <= 1'b1;
          resp_valid_q  <= 1'b1;
          resp_err_q    <= err_q;
          resp_rdata_q  <= rdata_q;
          resp_extend_q <= cap_size;
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_extend = resp_extend_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses and
// expected RAM accesses; a RAM model and a response monitor pop and compare.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int AW  = 32;
  localparam int TMO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(AW)) bus ();

  mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  ext;
    int          lat;
    time         t_acc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          delay;    // ack in this ACCESS cycle (1 = first); 0 = never
    int          exp_cyc;  // expected mem_req high cycles; -1 = unchecked
    logic [31:0] rdata;
  } acc_t;

  resp_t resp_q[$];
  acc_t  mem_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  logic  stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Response monitor
  resp_t e;
  always @(negedge clk) begin
    if (!reset && bus.resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", {31'b0, bus.resp_valid}, 32'd0);
      end else begin
        e = resp_q.pop_front();
        check("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_extend", {29'b0, bus.resp_extend}, {29'b0, e.ext});
        check("resp_latency", 32'(($time - e.t_acc + 5) / 10), 32'(e.lat));
      end
    end
  end

  // RAM model
  logic ram_active = 1'b0;
  logic ram_rogue  = 1'b0;
  int   ram_k      = 0;
  acc_t cur;
  logic hit;
  always @(negedge clk) begin
    hit = 1'b0;
    if (bus.mem_req === 1'b1) begin
      if (!ram_active) begin
        ram_active = 1'b1;
        ram_k      = 0;
        if (mem_q.size() == 0) begin
          ram_rogue = 1'b1;
          check("unexpected_mem_req", {31'b0, bus.mem_req}, 32'd0);
        end else begin
          ram_rogue = 1'b0;
          cur       = mem_q.pop_front();
        end
      end
      ram_k++;
      if (!ram_rogue) begin
        check("mem_addr", bus.mem_addr, cur.addr);
        check("mem_be", {28'b0, bus.mem_be}, {28'b0, cur.be});
        check("mem_we", {31'b0, bus.mem_we}, {31'b0, cur.we});
        check("mem_wdata", bus.mem_wdata, cur.wdata);
        hit = (cur.delay == ram_k);
      end
    end else if (ram_active) begin
      ram_active = 1'b0;
      if (!ram_rogue && cur.exp_cyc >= 0)
        check("mem_req_cycles", 32'(ram_k), 32'(cur.exp_cyc));
    end
    bus.mem_ack   = hit | stray_ack;
    bus.mem_rdata = hit ? cur.rdata : 32'h0;
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                       input int exp_lat, input logic exp_acc, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input int delay, input int exp_cyc,
                       input logic [31:0] ram_word);
    acc_t  a;
    resp_t r;
    wait_ready();
    if (exp_acc) begin
      a.addr    = {addr[31:2], 2'b00};
      a.be      = exp_be;
      a.we      = wr;
      a.wdata   = exp_wd;
      a.delay   = delay;
      a.exp_cyc = exp_cyc;
      a.rdata   = ram_word;
      mem_q.push_back(a);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    r.err   = exp_err;
    r.rdata = exp_rd;
    r.ext   = sz;
    r.lat   = exp_lat;
    r.t_acc = $time;
    resp_q.push_back(r);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_resp_q", 32'(resp_q.size()), 32'd0);
    check("drain_mem_q", 32'(mem_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    check({tag, "_resp_err"}, {31'b0, bus.resp_err}, 32'd0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, "_resp_extend"}, {29'b0, bus.resp_extend}, 32'd0);
    check({tag, "_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, bus.mem_we}, 32'd0);
    check({tag, "_mem_be"}, {28'b0, bus.mem_be}, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    //     wr  size    addr       wdata         err rdata         lat acc be       exp_wdata     dly cyc ram_word
    issue(1, SZ_B,  32'h103, 32'h123456A5, 0, 32'h0,        4, 1, 4'b1000, 32'hA5000000, 2, 2, 32'h0);
    issue(0, SZ_HU, 32'h022, 32'h0,        0, 32'h0000BEEF, 3, 1, 4'b1100, 32'h0,        1, 1, 32'hBEEF1234);
    issue(0, SZ_W,  32'h006, 32'h0,        1, 32'h0,        2, 0, 4'b0000, 32'h0,        0, 0, 32'h0);
    issue(1, SZ_BU, 32'h010, 32'h55,       1, 32'h0,        2, 0, 4'b0000, 32'h0,        0, 0, 32'h0);
    issue(1, SZ_HU, 32'h020, 32'h55,       1, 32'h0,        2, 0, 4'b0000, 32'h0,        0, 0, 32'h0);
    issue(0, SZ_W,  32'h040, 32'h0,        1, 32'h0,        6, 1, 4'b1111, 32'h0,        0, 4, 32'h0);
    issue(0, SZ_W,  32'h044, 32'h0,        0, 32'hCAFEF00D, 6, 1, 4'b1111, 32'h0,        4, 4, 32'hCAFEF00D);
    issue(0, SZ_B,  32'h101, 32'h0,        0, 32'h00112233, 3, 1, 4'b0010, 32'h0,        1, 1, 32'h11223344);
    issue(1, SZ_H,  32'h00A, 32'hFFFF5678, 0, 32'h0,        5, 1, 4'b1100, 32'h56780000, 3, 3, 32'h0);
    issue(0, SZ_H,  32'h003, 32'h0,        1, 32'h0,        2, 0, 4'b0000, 32'h0,        0, 0, 32'h0);
    issue(1, SZ_W,  32'h00C, 32'hDEADBEEF, 0, 32'h0,        3, 1, 4'b1111, 32'hDEADBEEF, 1, 1, 32'h0);
    issue(0, 3'b011, 32'h000, 32'h0,       1, 32'h0,        2, 0, 4'b0000, 32'h0,        0, 0, 32'h0);
    issue(0, SZ_BU, 32'h033, 32'h0,        0, 32'h00000089, 3, 1, 4'b1000, 32'h0,        1, 1, 32'h89ABCDEF);
    drain();

    // Reset in the middle of an access, then a late ack must be ignored.
    begin
      acc_t a;
      wait_ready();
      a.addr    = 32'h80;
      a.be      = 4'b1111;
      a.we      = 1'b0;
      a.wdata   = 32'h0;
      a.delay   = 0;
      a.exp_cyc = -1;
      a.rdata   = 32'h0;
      mem_q.push_back(a);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = SZ_W;
      bus.req_addr  = 32'h80;
      bus.req_wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("mem_req_before_reset", {31'b0, bus.mem_req}, 32'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #2 stray_ack = 1'b1;
      @(posedge clk);
      #2 stray_ack = 1'b0;
      repeat (4) @(negedge clk);
      check_reset_outputs("post_reset");
    end

    issue(0, SZ_H, 32'h092, 32'h0, 0, 32'h00007788, 4, 1, 4'b1100, 32'h0, 2, 2, 32'h77885566);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
